// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and stop-period tick counts.
package uart_tx_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    // s_tick counts for the stop period
    localparam int unsigned STOP_1   = 16;
    localparam int unsigned STOP_1P5 = 24;
    localparam int unsigned STOP_2   = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between the interface FSM/FIFO and the transmitter.
interface uart_tx_if #(
    parameter int unsigned DBIT = 8
);
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx_busy;
    logic            tx_done_tick;
    logic            tx;

    modport master (
        output tx_start, din,
        input  tx_busy, tx_done_tick, tx
    );

    modport slave (
        input  tx_start, din,
        output tx_busy, tx_done_tick, tx
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      s_tick,
    uart_tx_if.slave  bus
);

    localparam int unsigned SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int unsigned NW = $clog2(DBIT);

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; outputs are derived from the next state so they switch with it
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                // done_q blocks a restart in the cycle that reports completion
                if (bus.tx_start && !done_q) begin
                    state_d = START;
                    s_d     = '0;
                    b_d     = bus.din;
                    par_d   = (^bus.din) ^ (PARITY_ODD != 0);
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(OVERSAMPLE - 1)) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(OVERSAMPLE - 1)) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == SW'(OVERSAMPLE - 1)) begin
                        state_d = STOP;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = busy_q;
    assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven in parallel against a frame-level reference model.
module tb_uart_tx;
    import uart_tx_pkg::*;

    // cfg0: 8N1, cfg1: 8E1, cfg2: 8O1, cfg3: 8N2
    localparam int unsigned PE_C[4] = '{0, 1, 1, 0};
    localparam int unsigned PO_C[4] = '{0, 0, 1, 0};
    localparam int unsigned SB_C[4] = '{STOP_1, STOP_1, STOP_1, STOP_2};

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;

    always #5 clk = ~clk;

    uart_tx_if #(.DBIT(8)) if0 ();
    uart_tx_if #(.DBIT(8)) if1 ();
    uart_tx_if #(.DBIT(8)) if2 ();
    uart_tx_if #(.DBIT(8)) if3 ();

    assign if0.tx_start = tx_start;
    assign if1.tx_start = tx_start;
    assign if2.tx_start = tx_start;
    assign if3.tx_start = tx_start;
    assign if0.din = din;
    assign if1.din = din;
    assign if2.din = din;
    assign if3.din = din;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0))
        dut0 (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(if0));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0))
        dut1 (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(if1));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1))
        dut2 (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(if2));
    uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0))
        dut3 (.clk(clk), .reset(reset), .s_tick(s_tick), .bus(if3));

    logic [3:0] tx_v, busy_v, done_v;
    assign tx_v   = {if3.tx, if2.tx, if1.tx, if0.tx};
    assign busy_v = {if3.tx_busy, if2.tx_busy, if1.tx_busy, if0.tx_busy};
    assign done_v = {if3.tx_done_tick, if2.tx_done_tick, if1.tx_done_tick, if0.tx_done_tick};

    // Reference model: a frame is a count of ticks since acceptance; the line level follows from it
    function automatic int unsigned frame_len(input int c);
        return OVERSAMPLE * (1 + 8 + PE_C[c]) + SB_C[c];
    endfunction

    function automatic logic level(input int c, input int unsigned k, input logic [7:0] d);
        int unsigned seg;
        seg = k / OVERSAMPLE;
        if (seg == 0) return 1'b0;
        if (seg <= 8) return d[seg-1];
        if (PE_C[c] != 0 && seg == 9) return (($countones(d) % 2) == 1) ^ (PO_C[c] != 0);
        return 1'b1;
    endfunction

    logic        m_act[4];
    int unsigned m_cnt[4];
    logic [7:0]  m_data[4];
    logic        m_done[4];
    logic        m_tx[4];

    // Model bookkeeping
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                m_act[c]  <= 1'b0;
                m_cnt[c]  <= 0;
                m_data[c] <= 8'h00;
                m_done[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_done[c] <= 1'b0;
                if (m_act[c]) begin
                    if (s_tick) begin
                        if (m_cnt[c] + 1 == frame_len(c)) begin
                            m_act[c]  <= 1'b0;
                            m_done[c] <= 1'b1;
                            m_cnt[c]  <= 0;
                        end else begin
                            m_cnt[c] <= m_cnt[c] + 1;
                        end
                    end
                end else if (tx_start && !m_done[c]) begin
                    m_act[c]  <= 1'b1;
                    m_cnt[c]  <= 0;
                    m_data[c] <= din;
                end
            end
        end
    end

    // Model line level
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            m_tx[c] = m_act[c] ? level(c, m_cnt[c], m_data[c]) : 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int id, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d: got 0x%0h required 0x%0h at %0t", name, id, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        for (int c = 0; c < 4; c++) begin
            check("model_tx",   c, 10'(tx_v[c]),   10'(m_tx[c]));
            check("model_busy", c, 10'(busy_v[c]), 10'(m_act[c]));
            check("model_done", c, 10'(done_v[c]), 10'(m_done[c]));
        end
    endtask

    // One clock with the given inputs, then compare every DUT against the model
    task automatic step(input logic tk, input logic st, input logic [7:0] d);
        s_tick   = tk;
        tx_start = st;
        din      = d;
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_v != 4'h0 || done_v != 4'h0) && n < 2000) begin
            step(1'b1, 1'b0, 8'h00);
            n++;
        end
        check("wait_idle", 0, 10'(busy_v), 10'h000);
        step(1'b0, 1'b0, 8'h00);
    endtask

    typedef struct {
        logic [7:0] din;
        int         period;
        logic [9:0] exp_seq;      // line level per bit slot, bit 0 = start bit
        logic       exp_par_even;
    } vec_t;

    vec_t vecs[6];

    // Send one frame with s_tick every 'period' clocks; check slot levels, parity and done timing
    task automatic run_vec(input vec_t v);
        logic [9:0] seg;
        logic       p_even, p_odd;
        int         k;
        seg    = '0;
        p_even = 1'b0;
        p_odd  = 1'b0;
        step(1'b0, 1'b1, v.din);
        check("start_latency_tx", 0, 10'(tx_v[0]), 10'h000);
        check("start_latency_busy", 0, 10'(busy_v[0]), 10'h001);
        for (k = 1; k <= 176; k++) begin
            for (int i = 1; i < v.period; i++) step(1'b0, 1'b0, 8'($urandom));
            step(1'b1, 1'b0, 8'($urandom));
            if (k % 16 == 8 && k / 16 <= 9) seg[k/16] = tx_v[0];
            if (k == 152) begin
                p_even = tx_v[1];
                p_odd  = tx_v[2];
            end
            if (k == 159) check("done0_early", 0, 10'(done_v[0]), 10'h000);
            if (k == 160) check("done0_at_160", 0, 10'(done_v[0]), 10'h001);
            if (k == 175) check("stop2_high", 3, 10'({done_v[3], tx_v[3]}), 10'h001);
            if (k == 176) check("done3_at_176", 3, 10'(done_v[3]), 10'h001);
            if (k == 176) check("done1_at_176", 1, 10'(done_v[1]), 10'h001);
        end
        for (int b = 0; b < 10; b++) check($sformatf("slot%0d_din%02h", b, v.din), 0, 10'(seg[b]), 10'(v.exp_seq[b]));
        check("parity_even", 1, 10'(p_even), 10'(v.exp_par_even));
        check("parity_odd",  2, 10'(p_odd),  10'(!v.exp_par_even));
        wait_idle();
    endtask

    initial begin
        logic [7:0] got;
        int         k;
        int         n;

        vecs[0] = '{din: 8'hA5, period: 1, exp_seq: 10'h34A, exp_par_even: 1'b0};
        vecs[1] = '{din: 8'h07, period: 4, exp_seq: 10'h20E, exp_par_even: 1'b1};
        vecs[2] = '{din: 8'h00, period: 1, exp_seq: 10'h200, exp_par_even: 1'b0};
        vecs[3] = '{din: 8'hFF, period: 2, exp_seq: 10'h3FE, exp_par_even: 1'b0};
        vecs[4] = '{din: 8'h3C, period: 3, exp_seq: 10'h278, exp_par_even: 1'b0};
        vecs[5] = '{din: 8'h80, period: 1, exp_seq: 10'h300, exp_par_even: 1'b1};

        reset    = 1'b0;
        s_tick   = 1'b0;
        tx_start = 1'b0;
        din      = 8'h00;
        @(negedge clk);
        step(1'b1, 1'b1, 8'h55);
        check("reset_tx",   0, 10'(tx_v),   10'h00F);
        check("reset_busy", 0, 10'(busy_v), 10'h000);
        check("reset_done", 0, 10'(done_v), 10'h000);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // s_tick stalls for 100 clocks inside the start bit
        step(1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 8'($urandom));
        check("stall_start_low", 0, 10'({busy_v[0], tx_v[0]}), 10'h002);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
        check("stall_tick15_low", 0, 10'(tx_v[0]), 10'h000);
        step(1'b1, 1'b0, 8'h00);
        check("stall_bit0", 0, 10'(tx_v[0]), 10'h001);
        wait_idle();

        // tx_start held high with din churning; restart waits for the cycle after tx_done_tick
        step(1'b0, 1'b1, 8'h5A);
        got = 8'h00;
        k = 0;
        n = 0;
        while (done_v[0] !== 1'b1 && n < 400) begin
            step(1'b1, 1'b1, 8'($urandom));
            k++;
            n++;
            if (k % 16 == 8 && k / 16 >= 1 && k / 16 <= 8) got[k/16-1] = tx_v[0];
        end
        check("held_done_seen", 0, 10'(done_v[0]), 10'h001);
        check("held_frame_data", 0, 10'(got), 10'h05A);
        step(1'b1, 1'b1, 8'hC3);
        check("held_gap_idle", 0, 10'({busy_v[0], tx_v[0]}), 10'h001);
        step(1'b1, 1'b1, 8'h96);
        check("held_restart", 0, 10'({busy_v[0], tx_v[0]}), 10'h002);
        got = 8'h00;
        for (k = 1; k <= 144; k++) begin
            step(1'b1, 1'b0, 8'($urandom));
            if (k % 16 == 8 && k / 16 >= 1) got[k/16-1] = tx_v[0];
        end
        check("held_second_data", 0, 10'(got), 10'h096);
        wait_idle();

        // Asynchronous reset in the middle of data bit 3, then a clean frame
        step(1'b0, 1'b1, 8'hF0);
        for (k = 1; k <= 16 * 4 + 5; k++) step(1'b1, 1'b0, 8'h00);
        check("pre_reset_bit3", 0, 10'(tx_v[0]), 10'h000);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx",   0, 10'(tx_v),   10'h00F);
        check("async_rst_busy", 0, 10'(busy_v), 10'h000);
        check("async_rst_done", 0, 10'(done_v), 10'h000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h00);
        run_vec(vecs[4]);

        // Random ticks, requests and data
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises one parallel byte into a frame of start bit, DBIT data bits (LSB first), optional parity bit and stop bit(s) on the tx line.
- Bit timing comes from the s_tick strobe produced by the team's mod-M tick generator, configured for 16x the baud rate.
- Sits beside the UART receiver in the UART top level. Driven by the interface FSM/FIFO through a tx_start / tx_done_tick handshake.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- SB_TICK, 16, s_tick count for the stop period: 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- s_tick  in  1  one-clk strobe at 16x baud rate.
- tx_start  in  1  request to send din; sampled only in IDLE.
- din  in  DBIT  byte to send; sampled in the cycle tx_start is accepted.
- tx_busy  out  1  high in every state except IDLE.
- tx_done_tick  out  1  one-clk pulse at the end of the stop period.
- tx  out  1  serial line, registered, idle high.

Behaviour:
- Reset (reset=0, async): state=IDLE, s_reg=0, n_reg=0, b_reg=0, par_reg=0, tx=1, tx_busy=0, tx_done_tick=0. Reset mid-frame aborts the frame; tx returns high immediately.
- States and timing:
  - IDLE: tx=1. On tx_start=1, latch b_reg<=din and par_reg<=(^din)^PARITY_ODD, clear s_reg, go to START. The next cycle shows tx=0 and tx_busy=1, a latency of 1 clk.
  - START: tx=0. On each s_tick, if s_reg==15 then s_reg<=0, n_reg<=0 and go to DATA; else s_reg++.
  - DATA: tx=b_reg[0]. On s_tick with s_reg==15: s_reg<=0 and b_reg shifts right. If n_reg==DBIT-1, go to PARITY (PARITY_EN=1) or STOP; else n_reg++. Any other s_tick increments s_reg.
  - PARITY: tx=par_reg. On s_tick with s_reg==15, clear s_reg and go to STOP.
  - STOP: tx=1. On s_tick with s_reg==SB_TICK-1, go to IDLE and assert tx_done_tick for that one clk.
- Counters advance only on s_tick. Without s_tick the FSM holds its state and tx.
- s_reg width is clog2(max(16,SB_TICK)); n_reg width is clog2(DBIT).
- tx is driven from a register loaded with the next-state output value, so it changes in the same cycle as the state register and is glitch-free.
- Frame length is 16*(1+DBIT+PARITY_EN)+SB_TICK ticks.
- tx_start outside IDLE (including the tx_done_tick cycle) is ignored and din is not re-sampled. Back-to-back frames therefore have at least one idle clk between them.
- din changes after acceptance have no effect on the frame in flight.

Decomposition:
- Shared uart package holds:
  - state encodings (IDLE, START, DATA, PARITY, STOP; 3-bit);
  - OVERSAMPLE=16;
  - the stop-tick constants for 1, 1.5 and 2 stop bits.
- The receiver uses the same package.
- No sub-module: the tick generator is instantiated at the UART top level and shared with the receiver. Parity is an inline reduction.

Test Plan:
- DBIT=8, no parity, s_tick every clk, din=0xA5, tx_start 1 clk -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 16 clks; tx_done_tick one clk after 160 ticks; tx_busy high throughout.
- PARITY_EN=1, even parity, din=0x07, s_tick every 4 clks -> parity bit=1 held 64 clks after the last data bit. Then PARITY_ODD=1 -> parity bit=0.
- SB_TICK=32, din=0x00 -> stop high for exactly 32 ticks before tx_done_tick; total 176 ticks.
- tx_start held high continuously with din changing mid-frame -> first frame is unchanged; the next frame starts exactly 1 clk after tx_done_tick with din sampled at that cycle.
- Reset pulled low during DATA bit 3 -> tx=1, tx_busy=0 asynchronously; no tx_done_tick. After release, a new tx_start with 0x3C sends a clean frame.
- s_tick stalled for 100 clks in the middle of START -> tx stays 0; the frame resumes with the remaining tick count intact.
